// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Fetch stage for the small button-loaded CPU. On start it takes a snapshot of
// the instruction image and the hazard (bubble) image. It then walks a PC over
// the slots and presents each instruction in the IF/ID register, preceded by
// the requested number of bubble cycles. The IF/ID register uses a valid/ready
// handshake towards decode.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   instrMemBits   instruction image, slot i = bits [8i+7:8i]
//   hazardMemBits  hazard image, byte i bits [1:0] = bubbles before slot i
//   start          single-cycle run request (IDLE / DONE only)
//   flush          synchronous abort back to IDLE, highest priority
//   id_ready       decode accepts the IF/ID register this cycle
//   if_id_valid    IF/ID holds a real instruction
//   if_id_instr    instruction, or NOP_OPCODE when not valid
//   if_id_pc       slot index of if_id_instr
//   busy           FSM in RUN
//   done           FSM in DONE
//
// Build option:
//   FETCH_LOOP_EN  when defined, reaching HALT_OPCODE or the last slot restarts
//                  at slot 0 instead of finishing; done is then always 0.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int         NUM_SLOTS   = 8,
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter logic [7:0] NOP_OPCODE  = 8'h00,
  localparam int        PC_W        = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SLOTS*8-1:0] instrMemBits,
  input  logic [NUM_SLOTS*8-1:0] hazardMemBits,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   id_ready,
  output logic                   if_id_valid,
  output logic [7:0]             if_id_instr,
  output logic [PC_W-1:0]        if_id_pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(NUM_SLOTS - 1);

  state_t                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [NUM_SLOTS*8-1:0]   instr_snap_q, instr_snap_d;
  logic [NUM_SLOTS*2-1:0]   haz_snap_q, haz_snap_d;
  logic                     valid_q, valid_d;
  logic [7:0]               instr_q, instr_d;
  logic [PC_W-1:0]          ifpc_q, ifpc_d;

  // Only the low two bits of each hazard byte carry information.
  logic [NUM_SLOTS*2-1:0]   haz_in_w;
  logic [7:0]               slot_w [NUM_SLOTS];
  logic [1:0]               bub_w  [NUM_SLOTS];
  logic                     unused_hazard_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign haz_in_w[2*gi +: 2] = hazardMemBits[8*gi +: 2];
      assign slot_w[gi]          = instr_snap_q[8*gi +: 8];
      assign bub_w[gi]           = haz_snap_q[2*gi +: 2];
    end
  endgenerate

  assign unused_hazard_w = ^hazardMemBits;

  logic            advance_w;
  logic [PC_W-1:0] next_idx_w;

  // The IF/ID register may only change when it is empty or being consumed.
  assign advance_w  = !valid_q || id_ready;
  // Slot whose bubbles follow the current one; restarts at 0 after the last.
  assign next_idx_w = (pc_q == LAST_PC) ? '0 : pc_q + PC_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    instr_snap_d = instr_snap_q;
    haz_snap_d   = haz_snap_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          instr_snap_d = instrMemBits;
          haz_snap_d   = haz_in_w;
          pc_d         = '0;
          cnt_d        = haz_in_w[1:0];
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (advance_w) begin
          if (cnt_q != 2'd0) begin
            valid_d = 1'b0;
            instr_d = NOP_OPCODE;
            cnt_d   = cnt_q - 2'd1;
          end else if (slot_w[pc_q] == HALT_OPCODE) begin
            valid_d = 1'b0;
            instr_d = NOP_OPCODE;
`ifdef FETCH_LOOP_EN
            pc_d    = '0;
            cnt_d   = bub_w[0];
`else
            state_d = ST_DONE;
`endif
          end else begin
            valid_d = 1'b1;
            instr_d = slot_w[pc_q];
            ifpc_d  = pc_q;
            cnt_d   = bub_w[next_idx_w];
            if (pc_q == LAST_PC) begin
`ifdef FETCH_LOOP_EN
              pc_d    = '0;
`else
              state_d = ST_DONE;
`endif
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        // A restart is only taken on an edge where nothing is left pending.
        if (advance_w) begin
          valid_d = 1'b0;
          instr_d = NOP_OPCODE;
          if (start) begin
            instr_snap_d = instrMemBits;
            haz_snap_d   = haz_in_w;
            pc_d         = '0;
            cnt_d        = haz_in_w[1:0];
            state_d      = ST_RUN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_OPCODE;
      ifpc_d  = '0;
      pc_d    = '0;
      cnt_d   = 2'd0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      cnt_q        <= 2'd0;
      instr_snap_q <= '0;
      haz_snap_q   <= '0;
      valid_q      <= 1'b0;
      instr_q      <= 8'h00;
      ifpc_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      instr_snap_q <= instr_snap_d;
      haz_snap_q   <= haz_snap_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
    end
  end

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign busy        = (state_q == ST_RUN);
`ifdef FETCH_LOOP_EN
  assign done        = 1'b0;
`else
  assign done        = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. Each check prints one line; the final
// line gives the error and check counts. The looping variant is exercised only
// when FETCH_LOOP_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] instrMemBits;
  logic [63:0] hazardMemBits;
  logic        start;
  logic        flush;
  logic        id_ready;
  logic        if_id_valid;
  logic [7:0]  if_id_instr;
  logic [2:0]  if_id_pc;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instrMemBits (instrMemBits),
    .hazardMemBits(hazardMemBits),
    .start        (start),
    .flush        (flush),
    .id_ready     (id_ready),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] IMG_A    = 64'h0000_0000_008A_8988;
  localparam logic [63:0] IMG_HALT = 64'h0000_0000_FF8A_8988;
  localparam logic [63:0] IMG_LOOP = 64'h0000_0000_00FF_8988;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [7:0] ins, input logic [2:0] pc);
    chk($sformatf("%s valid", tag), 64'(if_id_valid), 64'(v));
    chk($sformatf("%s instr", tag), 64'(if_id_instr), 64'(ins));
    chk($sformatf("%s pc", tag), 64'(if_id_pc), 64'(pc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_a [8];
    exp_a = '{8'h88, 8'h89, 8'h8A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    rst_n         = 1'b0;
    instrMemBits  = '0;
    hazardMemBits = '0;
    start         = 1'b0;
    flush         = 1'b0;
    id_ready      = 1'b1;
    #3;
    chk_if("reset", 1'b0, 8'h00, 3'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle busy", 64'(busy), 64'd0);

`ifndef FETCH_LOOP_EN
    // 1: plain run, no bubbles
    instrMemBits = IMG_A;
    pulse_start();
    chk("t1 busy after start", 64'(busy), 64'd1);
    chk("t1 valid after start", 64'(if_id_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_if($sformatf("t1 slot%0d", i), 1'b1, exp_a[i], 3'(i));
      chk($sformatf("t1 busy%0d", i), 64'(busy), (i < 7) ? 64'd1 : 64'd0);
    end
    chk("t1 done", 64'(done), 64'd1);
    step();
    chk("t1 valid cleared", 64'(if_id_valid), 64'd0);
    chk("t1 done held", 64'(done), 64'd1);

    // 2: two bubbles before slot 1
    hazardMemBits = 64'h0000_0000_0000_0200;
    pulse_start();
    step();
    chk_if("t2 slot0", 1'b1, 8'h88, 3'd0);
    step();
    chk("t2 bubble1 valid", 64'(if_id_valid), 64'd0);
    chk("t2 bubble1 instr", 64'(if_id_instr), 64'h00);
    step();
    chk("t2 bubble2 valid", 64'(if_id_valid), 64'd0);
    step();
    chk_if("t2 slot1", 1'b1, 8'h89, 3'd1);
    for (int i = 2; i < 8; i++) begin
      step();
      chk_if($sformatf("t2 slot%0d", i), 1'b1, exp_a[i], 3'(i));
    end
    chk("t2 done", 64'(done), 64'd1);
    step();
    hazardMemBits = '0;

    // 3: halt in slot 3
    instrMemBits = IMG_HALT;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if($sformatf("t3 slot%0d", i), 1'b1, exp_a[i], 3'(i));
    end
    step();
    chk("t3 halt valid", 64'(if_id_valid), 64'd0);
    chk("t3 halt instr", 64'(if_id_instr), 64'h00);
    chk("t3 done", 64'(done), 64'd1);
    chk("t3 busy", 64'(busy), 64'd0);

    // 4: backpressure on slot 1, image changed mid-run
    instrMemBits = IMG_A;
    pulse_start();
    step();
    chk_if("t4 slot0", 1'b1, 8'h88, 3'd0);
    step();
    chk_if("t4 slot1", 1'b1, 8'h89, 3'd1);
    id_ready     = 1'b0;
    instrMemBits = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if($sformatf("t4 hold%0d", i), 1'b1, 8'h89, 3'd1);
    end
    id_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      step();
      chk_if($sformatf("t4 slot%0d", i), 1'b1, exp_a[i], 3'(i));
    end
    chk("t4 done", 64'(done), 64'd1);
    step();

    // 5: flush with pc=4, then async reset mid-run
    instrMemBits = IMG_A;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk_if("t5 slot3", 1'b1, 8'h00, 3'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_if("t5 flush", 1'b0, 8'h00, 3'd0);
    chk("t5 flush busy", 64'(busy), 64'd0);
    chk("t5 flush done", 64'(done), 64'd0);
    step();
    chk("t5 stays idle", 64'(busy), 64'd0);
    pulse_start();
    step();
    step();
    chk_if("t5 run2 slot1", 1'b1, 8'h89, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_if("t5 async reset", 1'b0, 8'h00, 3'd0);
    chk("t5 reset busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5 post reset busy", 64'(busy), 64'd0);
    pulse_start();
    step();
    chk_if("t5 restart slot0", 1'b1, 8'h88, 3'd0);
`else
    // 6: looping on halt in slot 2
    instrMemBits = IMG_LOOP;
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      step();
      chk_if($sformatf("t6 r%0d slot0", r), 1'b1, 8'h88, 3'd0);
      step();
      chk_if($sformatf("t6 r%0d slot1", r), 1'b1, 8'h89, 3'd1);
      step();
      chk($sformatf("t6 r%0d halt valid", r), 64'(if_id_valid), 64'd0);
      chk($sformatf("t6 r%0d done", r), 64'(done), 64'd0);
      chk($sformatf("t6 r%0d busy", r), 64'(busy), 64'd1);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6 flush busy", 64'(busy), 64'd0);
    chk("t6 flush valid", 64'(if_id_valid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
